acc_cpu_core: RTL

- Parametrised successor to the fixed 8-bit accumulator CPU: multi-cycle accumulator core with configurable data and address widths.
- Adds a req/ack handshake to external instruction memory, a valid-qualified input bus, a strobed output bus, carry/zero flags and a halt state.
- Sits between instruction ROM and the top-level I/O pins.
- Debug outputs (pc, ins, flags, state) stay visible for benches.

---
 rtl/acc_cpu_core.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU with req/ack instruction fetch, valid-qualified input bus and strobed output bus.
// Latency: 2 cycles per instruction with zero-wait ack (FETCH + EXEC); each fetch wait cycle adds one.
// Backpressure: FETCH holds req/addr until imem_ack_i; IN stalls in WAIT_IN until aib_valid_i; output bus is never stalled.
//
// Ports:
//   clk_i, rst_ni                     clock (rising edge), async active-low reset
//   imem_req_o/addr_o/ack_i/data_i    instruction fetch handshake (addr = pc)
//   aib_i, aib_valid_i                input bus, sampled by IN when valid
//   aob_o, aob_valid_o                registered output bus, one-cycle strobe after OUT
//   pc_o, ins_o, acc_o, flags_o       debug view: pc, latched instruction, accumulator, {carry, zero}
//   state_o, halted_o                 FSM state (FETCH=0, EXEC=1, WAIT_IN=2, HALT=3), halt indicator
module acc_cpu_core #(
  parameter int DATA_W = 8,   // 4..32
  parameter int ADDR_W = 12,  // must be >= DATA_W so imm fits in the operand
  parameter int OPC_W  = 4,   // ISA opcode width, fixed at 4
  localparam int INS_W = OPC_W + ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INS_W-1:0]  imem_data_i,
  input  logic [DATA_W-1:0] aib_i,
  input  logic              aib_valid_i,
  output logic [DATA_W-1:0] aob_o,
  output logic              aob_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INS_W-1:0]  ins_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [1:0]        flags_o,
  output logic [1:0]        state_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_IN = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OPC_W-1:0] OP_ANDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_ORI  = 4'h5;
  localparam logic [OPC_W-1:0] OP_XORI = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OPC_W-1:0] OP_JC   = 4'h9;
  localparam logic [OPC_W-1:0] OP_IN   = 4'hA;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'hB;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'hC;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hD;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, operand;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic [DATA_W-1:0] acc_q, acc_d, imm, aob_q, aob_d;
  logic              c_q, c_d, z_q, z_d;
  logic              aob_vld_q, aob_vld_d;
  logic [OPC_W-1:0]  opc;
  logic [DATA_W:0]   add_res, sub_res;

  assign opc     = ins_q[INS_W-1:ADDR_W];
  assign operand = ins_q[ADDR_W-1:0];
  assign imm     = operand[DATA_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);  // wraps to 0 at the top of the address space

  // One extra bit catches the carry on add and the borrow on subtract.
  assign add_res = {1'b0, acc_q} + {1'b0, imm};
  assign sub_res = {1'b0, acc_q} - {1'b0, imm};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ins_q     <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      aob_q     <= '0;
      aob_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      z_q       <= z_d;
      aob_q     <= aob_d;
      aob_vld_q <= aob_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    acc_d     = acc_q;
    c_d       = c_q;
    z_d       = z_q;
    aob_d     = aob_q;
    aob_vld_d = 1'b0;  // strobe lives for exactly one cycle

    case (state_q)
      S_FETCH: begin
        if (imem_ack_i) begin
          ins_d   = imem_data_i;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opc)
          OP_LDI: begin
            acc_d = imm;
            z_d   = (imm == '0);
          end
          OP_ADDI: begin
            {c_d, acc_d} = add_res;
            z_d          = (add_res[DATA_W-1:0] == '0);
          end
          OP_SUBI: begin
            acc_d = sub_res[DATA_W-1:0];
            c_d   = sub_res[DATA_W];
            z_d   = (sub_res[DATA_W-1:0] == '0);
          end
          OP_ANDI: begin
            acc_d = acc_q & imm;
            z_d   = ((acc_q & imm) == '0);
          end
          OP_ORI: begin
            acc_d = acc_q | imm;
            z_d   = ((acc_q | imm) == '0);
          end
          OP_XORI: begin
            acc_d = acc_q ^ imm;
            z_d   = ((acc_q ^ imm) == '0);
          end
          OP_JMP: pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_IN: begin
            if (aib_valid_i) begin
              acc_d = aib_i;
              z_d   = (aib_i == '0);
            end else begin
              // pc stays put; WAIT_IN advances it once the data arrives
              pc_d    = pc_q;
              state_d = S_WAIT_IN;
            end
          end
          OP_OUT: begin
            aob_d     = acc_q;
            aob_vld_d = 1'b1;
          end
          OP_SHL: begin
            c_d   = acc_q[DATA_W-1];
            acc_d = {acc_q[DATA_W-2:0], 1'b0};
            z_d   = ({acc_q[DATA_W-2:0], 1'b0} == '0);
          end
          OP_SHR: begin
            c_d   = acc_q[0];
            acc_d = {1'b0, acc_q[DATA_W-1:1]};
            z_d   = ({1'b0, acc_q[DATA_W-1:1]} == '0);
          end
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;  // NOP and the reserved opcode
        endcase
      end

      S_WAIT_IN: begin
        if (aib_valid_i) begin
          acc_d   = aib_i;
          z_d     = (aib_i == '0);
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      default: ;  // HALT: everything frozen until reset
    endcase
  end

  // State resets to FETCH, so the request is gated by reset to keep it low while held.
  assign imem_req_o  = rst_ni & (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign aob_o       = aob_q;
  assign aob_valid_o = aob_vld_q;
  assign pc_o        = pc_q;
  assign ins_o       = ins_q;
  assign acc_o       = acc_q;
  assign flags_o     = {c_q, z_q};
  assign state_o     = state_q;
  assign halted_o    = (state_q == S_HALT);

endmodule
